// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter sequencer.
package pc_pkg;

  // Sequencer operating state.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Which source loads the pc at the next edge, highest priority last.
  typedef enum logic [2:0] {
    RedirHold = 3'd0,
    RedirSeq  = 3'd1,
    RedirBr   = 3'd2,
    RedirJr   = 3'd3,
    RedirTrap = 3'd4
  } redir_t;

  // Shift that turns an instruction-word offset into a byte offset.
  function automatic int unsigned inc_shift(input int unsigned inc);
    return $clog2(inc);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus redirect/control bundle of the pc sequencer.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OFFW = 26,
  parameter int unsigned CNTW = 32
);
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc;
  logic            br_take;
  logic [OFFW-1:0] br_off;
  logic            jr_take;
  logic [XLEN-1:0] jr_target;
  logic            trap;
  logic            halt;
  logic            resume;
  logic            misalign;
  logic [CNTW-1:0] fetch_cnt;

  // Sequencer side.
  modport master (
    input  fetch_ready, br_take, br_off, jr_take, jr_target, trap, halt, resume,
    output fetch_valid, pc, misalign, fetch_cnt
  );

  // Memory / branch-unit side.
  modport slave (
    output fetch_ready, br_take, br_off, jr_take, jr_target, trap, halt, resume,
    input  fetch_valid, pc, misalign, fetch_cnt
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-pc candidates: sequential, branch target and alignment flags.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned INC  = 4,
  parameter int unsigned OFFW = 26
) (
  input  logic [XLEN-1:0] pc,
  input  logic [OFFW-1:0] br_off,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] seq_target,
  output logic [XLEN-1:0] br_target,
  output logic            br_misalign,
  output logic            jr_misalign
);
  localparam int unsigned INC_SHIFT = inc_shift(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  logic [XLEN-1:0] off_ext;

  // Sign-extend before shifting so negative word offsets stay negative.
  always_comb begin
    off_ext     = {{(XLEN - OFFW){br_off[OFFW-1]}}, br_off};
    seq_target  = pc + XLEN'(INC);
    br_target   = pc + (off_ext << INC_SHIFT);
    br_misalign = (br_target & ALIGN_MASK) != '0;
    jr_misalign = (jr_target & ALIGN_MASK) != '0;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, next-PC selection, halt/resume control and accepted-fetch counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     OFFW      = 26,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(64'h100),
  parameter int unsigned     CNTW      = 32
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);
  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;
  redir_t          redir;
  logic            fetch_valid;
  logic            handshake;

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] br_target;
  logic            br_misalign;
  logic            jr_misalign;

  pc_target_calc #(
    .XLEN(XLEN),
    .INC (INC),
    .OFFW(OFFW)
  ) u_target_calc (
    .pc         (pc_q),
    .br_off     (bus.br_off),
    .jr_target  (bus.jr_target),
    .seq_target (seq_target),
    .br_target  (br_target),
    .br_misalign(br_misalign),
    .jr_misalign(jr_misalign)
  );

  assign fetch_valid     = (state_q == RUN);
  assign handshake       = fetch_valid & bus.fetch_ready;
  assign bus.fetch_valid = fetch_valid;
  assign bus.pc          = pc_q;
  assign bus.misalign    = mis_q;
  assign bus.fetch_cnt   = cnt_q;

  // Pick the pc source; in HALTED only a trap may move the pc.
  always_comb begin
    redir = RedirHold;
    unique case (state_q)
      RUN: begin
        if (bus.trap)             redir = RedirTrap;
        else if (bus.jr_take)     redir = RedirJr;
        else if (bus.br_take)     redir = RedirBr;
        else if (bus.fetch_ready) redir = RedirSeq;
      end
      HALTED: begin
        if (bus.trap) redir = RedirTrap;
      end
      default: redir = RedirHold;
    endcase
  end

  // Next pc, misalign pulse, state and counter.
  always_comb begin
    pc_d    = pc_q;
    mis_d   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (redir)
      RedirTrap: pc_d = TRAP_VEC;
      RedirJr: begin
        pc_d  = jr_misalign ? TRAP_VEC : bus.jr_target;
        mis_d = jr_misalign;
      end
      RedirBr: begin
        pc_d  = br_misalign ? TRAP_VEC : br_target;
        mis_d = br_misalign;
      end
      RedirSeq:  pc_d = seq_target;
      default:   pc_d = pc_q;
    endcase

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt && !bus.trap) state_d = HALTED;
      HALTED:  if (bus.trap || bus.resume) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // A redirect in the same cycle as a handshake still counts the fetch.
    if (handshake && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State, pc, counter and misalign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_pc_sequencer;
  localparam int unsigned XLEN = 64;
  localparam int unsigned INC  = 4;
  localparam int unsigned OFFW = 26;
  localparam int unsigned CNTW = 4;
  localparam logic [63:0] RSTV = 64'h0;
  localparam logic [63:0] TRAPV = 64'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN), .OFFW(OFFW), .CNTW(CNTW)) bus ();

  pc_sequencer #(
    .XLEN     (XLEN),
    .INC      (INC),
    .OFFW     (OFFW),
    .RESET_VEC(RSTV),
    .TRAP_VEC (TRAPV),
    .CNTW     (CNTW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 = booting, 1 = fetching, 2 = halted
  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  phase;
    logic        mis;
    logic [3:0]  cnt;
  } mstate_t;

  mstate_t m, m_nx;

  function automatic mstate_t model_next(input mstate_t cur);
    mstate_t nx;
    logic [63:0] tgt;
    longint off_bytes;
    nx = cur;
    nx.mis = 1'b0;
    if (cur.phase == 2'd1 && bus.fetch_ready && cur.cnt != 4'd15) nx.cnt = cur.cnt + 4'd1;
    if (cur.phase == 2'd0) begin
      nx.phase = 2'd1;
    end else if (cur.phase == 2'd1) begin
      if (bus.trap) begin
        nx.pc = TRAPV;
      end else if (bus.jr_take) begin
        tgt = bus.jr_target;
        if (tgt % INC != 0) begin nx.pc = TRAPV; nx.mis = 1'b1; end
        else nx.pc = tgt;
      end else if (bus.br_take) begin
        off_bytes = longint'($signed(bus.br_off)) * longint'(INC);
        tgt = cur.pc + 64'(off_bytes);
        if (tgt % INC != 0) begin nx.pc = TRAPV; nx.mis = 1'b1; end
        else nx.pc = tgt;
      end else if (bus.fetch_ready) begin
        nx.pc = cur.pc + 64'(INC);
      end
      if (bus.halt && !bus.trap) nx.phase = 2'd2;
    end else begin
      if (bus.trap) begin nx.pc = TRAPV; nx.phase = 2'd1; end
      else if (bus.resume) nx.phase = 2'd1;
    end
    return nx;
  endfunction

  always_comb m_nx = model_next(m);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{pc: RSTV, phase: 2'd0, mis: 1'b0, cnt: 4'd0};
    else        m <= m_nx;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model pc", bus.pc, m.pc);
      chk("model fetch_valid", 64'(bus.fetch_valid), 64'(m.phase == 2'd1));
      chk("model misalign", 64'(bus.misalign), 64'(m.mis));
      chk("model fetch_cnt", 64'(bus.fetch_cnt), 64'(m.cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.fetch_ready = 1'b1;
    bus.br_take = 1'b0;
    bus.br_off = '0;
    bus.jr_take = 1'b0;
    bus.jr_target = '0;
    bus.trap = 1'b0;
    bus.halt = 1'b0;
    bus.resume = 1'b0;

    // Reset state.
    #7;
    chk("reset pc", bus.pc, 64'h0);
    chk("reset valid", 64'(bus.fetch_valid), 64'd0);
    chk("reset cnt", 64'(bus.fetch_cnt), 64'd0);
    chk("reset misalign", 64'(bus.misalign), 64'd0);
    #1 rst_n = 1'b1;
    chk("boot valid", 64'(bus.fetch_valid), 64'd0);

    // 1. Sequential fetch.
    tick(); chk("t1 pc0", bus.pc, 64'h0); chk("t1 valid", 64'(bus.fetch_valid), 64'd1);
    tick(); chk("t1 pc4", bus.pc, 64'h4);
    tick(); chk("t1 pc8", bus.pc, 64'h8);
    tick(); chk("t1 pcC", bus.pc, 64'hC); chk("t1 cnt3", 64'(bus.fetch_cnt), 64'd3);
    tick(); chk("t1 pc10", bus.pc, 64'h10);

    // 4. Stall then trap.
    bus.fetch_ready = 1'b0;
    repeat (3) tick();
    chk("t4 stall pc", bus.pc, 64'h10); chk("t4 stall cnt", 64'(bus.fetch_cnt), 64'd4);
    bus.trap = 1'b1;
    tick(); chk("t4 trap pc", bus.pc, 64'h100);
    bus.trap = 1'b0;

    // 2. Branch, then jr wins over branch.
    bus.jr_take = 1'b1; bus.jr_target = 64'h40;
    tick(); chk("t2 jr 40", bus.pc, 64'h40);
    bus.jr_take = 1'b0; bus.br_take = 1'b1; bus.br_off = 26'h3FF_FFFE;
    tick(); chk("t2 br -2", bus.pc, 64'h38);
    bus.br_take = 1'b0; bus.jr_take = 1'b1; bus.jr_target = 64'h40;
    tick(); chk("t2 jr back", bus.pc, 64'h40);
    bus.br_take = 1'b1; bus.jr_target = 64'h200;
    tick(); chk("t2 jr wins", bus.pc, 64'h200);
    bus.br_take = 1'b0;

    // 3. Misaligned jump target.
    bus.jr_target = 64'h202;
    tick(); chk("t3 mis pc", bus.pc, 64'h100); chk("t3 mis pulse", 64'(bus.misalign), 64'd1);
    bus.jr_take = 1'b0;
    tick(); chk("t3 mis clear", 64'(bus.misalign), 64'd0);

    // 5. Halt with handshake, resume, trap while halted.
    bus.jr_take = 1'b1; bus.jr_target = 64'h20;
    tick(); chk("t5 pc20", bus.pc, 64'h20);
    bus.jr_take = 1'b0; bus.fetch_ready = 1'b1; bus.halt = 1'b1;
    tick(); chk("t5 halt pc", bus.pc, 64'h24); chk("t5 halt valid", 64'(bus.fetch_valid), 64'd0);
    chk("t5 halt cnt", 64'(bus.fetch_cnt), 64'd5);
    bus.halt = 1'b0;
    tick(); chk("t5 held pc", bus.pc, 64'h24); chk("t5 held cnt", 64'(bus.fetch_cnt), 64'd5);
    bus.resume = 1'b1;
    tick(); chk("t5 resume valid", 64'(bus.fetch_valid), 64'd1); chk("t5 resume pc", bus.pc, 64'h24);
    bus.resume = 1'b0; bus.fetch_ready = 1'b0; bus.halt = 1'b1;
    tick(); chk("t5 halt2 valid", 64'(bus.fetch_valid), 64'd0);
    bus.halt = 1'b0; bus.trap = 1'b1;
    tick(); chk("t5 htrap pc", bus.pc, 64'h100); chk("t5 htrap valid", 64'(bus.fetch_valid), 64'd1);
    bus.trap = 1'b0;
    // halt and trap together: trap wins, stays running.
    bus.jr_take = 1'b1; bus.jr_target = 64'h80;
    tick();
    bus.jr_take = 1'b0; bus.halt = 1'b1; bus.trap = 1'b1;
    tick(); chk("t5 ht pc", bus.pc, 64'h100); chk("t5 ht valid", 64'(bus.fetch_valid), 64'd1);
    bus.halt = 1'b0; bus.trap = 1'b0;

    // 6. Wrap-around, counter saturation, async reset.
    bus.jr_take = 1'b1; bus.jr_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.jr_take = 1'b0; bus.fetch_ready = 1'b1;
    tick(); chk("t6 wrap pc", bus.pc, 64'h0); chk("t6 wrap cnt", 64'(bus.fetch_cnt), 64'd6);
    repeat (12) tick();
    chk("t6 sat cnt", 64'(bus.fetch_cnt), 64'd15); chk("t6 run pc", bus.pc, 64'h30);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async pc", bus.pc, 64'h0); chk("t6 async valid", 64'(bus.fetch_valid), 64'd0);
    chk("t6 async cnt", 64'(bus.fetch_cnt), 64'd0);
    #3 rst_n = 1'b1;
    tick(); chk("t6 reboot valid", 64'(bus.fetch_valid), 64'd1); chk("t6 reboot pc", bus.pc, 64'h0);
    tick(); chk("t6 reboot pc4", bus.pc, 64'h4); chk("t6 reboot cnt", 64'(bus.fetch_cnt), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
